// File: rtl/tree_up_port_arbiter_if.sv
// Up-link arbitration bundle between the child-port requesters and the up-port arbiter.
// Latency: the bundle only carries wires; every timing property belongs to the arbiter.
// Backpressure: the arbiter's grant consumes requester head flits, and credit_in returns parent buffer slots.
// Ports: req/hdr/tail (per requester head flit), credit_in (parent freed one slot),
//        grant/flit_wr (flit consumed and written), owner/busy (lock status), credit_cnt/cred_err.
interface tree_up_port_arbiter_if #(
  parameter int K = 2,
  parameter int B = 4
);
  localparam int Kw = (K > 1) ? $clog2(K) : 1;
  localparam int Bw = $clog2(B + 1);

  logic [K-1:0]  req;
  logic [K-1:0]  hdr;
  logic [K-1:0]  tail;
  logic          credit_in;
  logic [K-1:0]  grant;
  logic          flit_wr;
  logic [Kw-1:0] owner;
  logic          busy;
  logic [Bw-1:0] credit_cnt;
  logic          cred_err;

  // Arbiter side.
  modport slave (
    input  req, hdr, tail, credit_in,
    output grant, flit_wr, owner, busy, credit_cnt, cred_err
  );

  // Requester/link side.
  modport master (
    output req, hdr, tail, credit_in,
    input  grant, flit_wr, owner, busy, credit_cnt, cred_err
  );
endinterface

// File: rtl/tree_up_port_arbiter.sv
// Packet-level round-robin arbiter with credit tracking for a tree-NoC leaf router's up port.
// Latency: grant/flit_wr are combinational (zero-cycle); lock, pointer and credit updates land on the next clk_i edge.
// Backpressure: no grant while the credit count is zero; a locked packet stalls (bubbles) when its owner drops req.
// Ports: clk_i, reset_i (synchronous, active-high); up_if (slave modport) carries req/hdr/tail/credit_in
//        in and grant/flit_wr/owner/busy/credit_cnt/cred_err out.
module tree_up_port_arbiter #(
  parameter int K = 2,
  parameter int B = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  tree_up_port_arbiter_if.slave   up_if
);
  localparam int Kw = (K > 1) ? $clog2(K) : 1;
  localparam int Bw = $clog2(B + 1);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [Kw-1:0] ptr_q, ptr_d;
  logic [Kw-1:0] owner_q, owner_d;
  logic [Bw-1:0] cred_q, cred_d;
  logic          err_q, err_d;

  logic [K-1:0]  cand;
  logic [K-1:0]  grant;
  logic          flit_wr;
  logic          can_send;
  logic          found;
  logic [Kw-1:0] win;
  logic [Kw-1:0] idx;

  // Modulo-K increment; handles non-power-of-two K explicitly.
  function automatic logic [Kw-1:0] inc_mod(input logic [Kw-1:0] v);
    return (v == Kw'(K - 1)) ? '0 : v + 1'b1;
  endfunction

  // Only the registered count matters: a credit arriving this cycle cannot unblock a send.
  assign can_send = (cred_q != '0);
  assign cand     = up_if.req & up_if.hdr;

  // Round-robin scan starting at ptr_q; first candidate found wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = ptr_q;
    for (int i = 0; i < K; i++) begin
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = idx;
      end
      idx = inc_mod(idx);
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    grant   = '0;
    unique case (state_q)
      IDLE: begin
        if (can_send && found) begin
          grant[win] = 1'b1;
          if (up_if.tail[win]) begin
            ptr_d = inc_mod(win);
          end else begin
            state_d = LOCKED;
            owner_d = win;
          end
        end
      end
      LOCKED: begin
        // Header bits are ignored here; only the owner's tail releases the lock.
        if (can_send && up_if.req[owner_q]) begin
          grant[owner_q] = 1'b1;
          if (up_if.tail[owner_q]) begin
            state_d = IDLE;
            ptr_d   = inc_mod(owner_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (reset_i) begin
      grant = '0;
    end
  end

  assign flit_wr = |grant;

  // A simultaneous send and credit return cancel out; a return with a full count is an overflow.
  always_comb begin
    cred_d = cred_q;
    err_d  = err_q;
    if (flit_wr && !up_if.credit_in) begin
      cred_d = cred_q - 1'b1;
    end else if (!flit_wr && up_if.credit_in) begin
      if (cred_q == Bw'(B)) begin
        err_d = 1'b1;
      end else begin
        cred_d = cred_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cred_q  <= Bw'(B);
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cred_q  <= cred_d;
      err_q   <= err_d;
    end
  end

  assign up_if.grant      = grant;
  assign up_if.flit_wr    = flit_wr;
  assign up_if.owner      = owner_q;
  assign up_if.busy       = (state_q == LOCKED);
  assign up_if.credit_cnt = cred_q;
  assign up_if.cred_err   = err_q;
endmodule

// File: tb/tb_tree_up_port_arbiter.sv
// Self-checking bench for tree_up_port_arbiter (K=2, B=4).
// A packet-level model predicts every output each cycle; directed vectors pin literal expectations.
// Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
module tb_tree_up_port_arbiter;
  localparam int K = 2;
  localparam int B = 4;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  tree_up_port_arbiter_if #(.K(K), .B(B)) ifc ();

  tree_up_port_arbiter #(.K(K), .B(B)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .up_if   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- packet-level model ----------------
  bit m_valid  = 1'b0;
  bit m_locked = 1'b0;
  int m_owner  = 0;
  int m_ptr    = 0;
  int m_cred   = 0;
  bit m_err    = 1'b0;

  // Which requester may move a flit now, or -1.
  function automatic int m_pick();
    if (m_cred == 0) return -1;
    if (m_locked) return ifc.req[m_owner] ? m_owner : -1;
    for (int n = 0; n < K; n++) begin
      int c;
      c = (m_ptr + n) % K;
      if (ifc.req[c] && ifc.hdr[c]) return c;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    int g;
    logic [1:0] eg;
    g  = m_pick();
    eg = 2'b00;
    if (g >= 0 && !reset) eg[g] = 1'b1;
    if (m_valid) begin
      chk("mdl_grant",   ifc.grant, eg);
      chk("mdl_flit_wr", ifc.flit_wr, |eg);
      chk("mdl_busy",    ifc.busy, m_locked);
      chk("mdl_owner",   ifc.owner, m_owner);
      chk("mdl_credit",  ifc.credit_cnt, m_cred);
      chk("mdl_err",     ifc.cred_err, m_err);
    end
    if (reset) begin
      m_valid = 1'b1; m_locked = 1'b0; m_owner = 0; m_ptr = 0; m_cred = B; m_err = 1'b0;
    end else if (m_valid) begin
      if (g >= 0) begin
        if (ifc.tail[g]) begin
          m_locked = 1'b0;
          m_ptr    = (g + 1) % K;
        end else begin
          m_locked = 1'b1;
          m_owner  = g;
        end
      end
      m_cred = m_cred - ((g >= 0) ? 1 : 0) + (ifc.credit_in ? 1 : 0);
      if (m_cred > B) begin
        m_cred = B;
        m_err  = 1'b1;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input logic rs, input logic [1:0] r, input logic [1:0] h,
                     input logic [1:0] t, input logic c);
    @(posedge clk);
    #1;
    reset = rs; ifc.req = r; ifc.hdr = h; ifc.tail = t; ifc.credit_in = c;
    @(negedge clk);
  endtask

  task automatic cl(input string nm, input logic [1:0] g, input logic b, input int cnt);
    chk({nm, "_grant"}, ifc.grant, g);
    chk({nm, "_busy"}, ifc.busy, b);
    chk({nm, "_credit"}, ifc.credit_cnt, cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0;
    reset = 1'b1;
    ifc.req = '0; ifc.hdr = '0; ifc.tail = '0; ifc.credit_in = 1'b0;

    // Reset defaults.
    cyc(1, 2'b00, 2'b00, 2'b00, 0);
    cyc(1, 2'b11, 2'b11, 2'b11, 0);
    cl("rst", 2'b00, 0, 4);
    chk("rst_err", ifc.cred_err, 1'b0);
    chk("rst_flit_wr", ifc.flit_wr, 1'b0);

    // Fair single-flit arbitration with credits returned every cycle.
    for (int i = 0; i < 4; i++) begin
      cyc(0, 2'b11, 2'b11, 2'b11, 1);
      cl("fair", (i % 2 == 0) ? 2'b01 : 2'b10, 0, 4);
    end

    // Packet lock: requester 0 sends H/body/T while requester 1 waits with a header.
    cyc(0, 2'b01, 2'b01, 2'b00, 1); cl("lock0", 2'b01, 0, 4);
    cyc(0, 2'b11, 2'b10, 2'b00, 1); cl("lock1", 2'b01, 1, 4);
    chk("lock1_owner", ifc.owner, 0);
    cyc(0, 2'b11, 2'b10, 2'b01, 1); cl("lock2", 2'b01, 1, 4);
    cyc(0, 2'b10, 2'b10, 2'b10, 1); cl("lock3", 2'b10, 0, 4);

    // Credit exhaustion: 6-flit packet from requester 0, no returns at first.
    cyc(0, 2'b01, 2'b01, 2'b00, 0); cl("cx0", 2'b01, 0, 4);
    cyc(0, 2'b01, 2'b00, 2'b00, 0); cl("cx1", 2'b01, 1, 3);
    cyc(0, 2'b01, 2'b00, 2'b00, 0); cl("cx2", 2'b01, 1, 2);
    cyc(0, 2'b01, 2'b00, 2'b00, 0); cl("cx3", 2'b01, 1, 1);
    cyc(0, 2'b01, 2'b00, 2'b00, 0); cl("cx4", 2'b00, 1, 0);
    cyc(0, 2'b01, 2'b00, 2'b00, 0); cl("cx5", 2'b00, 1, 0);
    cyc(0, 2'b01, 2'b00, 2'b00, 1); cl("cx6", 2'b00, 1, 0);
    cyc(0, 2'b01, 2'b00, 2'b00, 0); cl("cx7", 2'b01, 1, 1);
    cyc(0, 2'b01, 2'b00, 2'b00, 1); cl("cx8", 2'b00, 1, 0);
    cyc(0, 2'b01, 2'b00, 2'b01, 0); cl("cx9", 2'b01, 1, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 2'b00, 2'b00, 2'b00, 1);
      cl("refill", 2'b00, 0, i);
    end

    // Owner bubble: requester 1 wins from ptr=1, then stalls while requester 0 waits.
    cyc(0, 2'b11, 2'b11, 2'b00, 1); cl("bub0", 2'b10, 0, 4);
    for (int i = 0; i < 2; i++) begin
      cyc(0, 2'b01, 2'b01, 2'b00, 0);
      cl("bub_stall", 2'b00, 1, 4);
      chk("bub_owner", ifc.owner, 1);
    end
    cyc(0, 2'b10, 2'b00, 2'b10, 1); cl("bub3", 2'b10, 1, 4);

    // Overflow while full and idle.
    cyc(0, 2'b00, 2'b00, 2'b00, 1); cl("ovf0", 2'b00, 0, 4);
    chk("ovf0_err", ifc.cred_err, 1'b0);
    cyc(0, 2'b00, 2'b00, 2'b00, 0); cl("ovf1", 2'b00, 0, 4);
    chk("ovf1_err", ifc.cred_err, 1'b1);

    // Move ptr to 1, lock on requester 1, then reset mid-packet.
    cyc(0, 2'b01, 2'b01, 2'b01, 0); cl("pre0", 2'b01, 0, 4);
    cyc(0, 2'b10, 2'b10, 2'b00, 1); cl("pre1", 2'b10, 0, 3);
    cyc(1, 2'b01, 2'b01, 2'b00, 0); cl("midrst", 2'b00, 1, 3);
    cyc(0, 2'b11, 2'b11, 2'b11, 0); cl("post", 2'b01, 0, 4);
    chk("post_err", ifc.cred_err, 1'b0);

    cyc(0, 2'b00, 2'b00, 2'b00, 0);
    cyc(0, 2'b00, 2'b00, 2'b00, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
